// File: rtl/fp_operand_unpack_if.sv
// Handshake and data bundle for the binary32 operand unpacker.
// The master side presents operand pairs and consumes unpacked results;
// the slave side is the unpacker itself.
interface fp_operand_unpack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_a;
  logic        sign_b;
  logic [9:0]  exp_a;
  logic [9:0]  exp_b;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic [4:0]  shift_a;
  logic [4:0]  shift_b;
  logic [4:0]  class_a;
  logic [4:0]  class_b;

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid,
           sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
           shift_a, shift_b, class_a, class_b
  );

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid,
           sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
           shift_a, shift_b, class_a, class_b
  );
endinterface

// File: rtl/fp_operand_unpack.sv
// Binary32 operand unpacker: splits each operand of a pair into sign,
// unbiased exponent and a 24-bit significand with explicit leading one,
// classifies it, and normalizes subnormals one bit per cycle.
module fp_operand_unpack (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_operand_unpack_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // One unpacked operand. cls = {is_snan, is_nan, is_inf, is_zero, is_sub}.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic [4:0]  shift;
    logic [4:0]  cls;
  } unpacked_t;

  state_t    state_q, state_d;
  unpacked_t a_q, a_d;
  unpacked_t b_q, b_d;
  logic      in_ready_q, in_ready_d;
  logic      out_valid_q, out_valid_d;

  // Split a raw binary32 word into its unpacked form and class flags.
  function automatic unpacked_t classify(input logic [31:0] op);
    unpacked_t   r;
    logic [7:0]  e;
    logic [22:0] f;
    e      = op[30:23];
    f      = op[22:0];
    r      = '0;
    r.sign = op[31];
    if (e == 8'd0) begin
      if (f == 23'd0) begin
        r.cls = 5'b00010;
      end else begin
        // Subnormal: hidden bit is 0 and the exponent is pinned at -126.
        r.mant = {1'b0, f};
        r.exp  = -10'sd126;
        r.cls  = 5'b00001;
      end
    end else if (e == 8'hFF) begin
      r.exp = 10'd128;
      if (f == 23'd0) begin
        r.mant = 24'h800000;
        r.cls  = 5'b00100;
      end else begin
        // Quiet bit clear marks a signalling NaN.
        r.mant = {1'b1, f};
        r.cls  = {~f[22], 1'b1, 3'b000};
      end
    end else begin
      r.mant = {1'b1, f};
      r.exp  = {2'b00, e} - 10'd127;
    end
    return r;
  endfunction

  // A subnormal still lacking its leading one needs another shift.
  function automatic logic needs_shift(input unpacked_t u);
    return u.cls[0] & ~u.mant[23];
  endfunction

  // Apply one normalization step if the operand still needs it.
  function automatic unpacked_t norm_step(input unpacked_t u);
    unpacked_t r;
    r = u;
    if (needs_shift(u)) begin
      r.mant  = {u.mant[22:0], 1'b0};
      r.exp   = u.exp - 10'd1;
      r.shift = u.shift + 5'd1;
    end
    return r;
  endfunction

  // Next-state and next-output logic for the IDLE/NORM/DONE sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          a_d        = classify(bus.op_a);
          b_d        = classify(bus.op_b);
          in_ready_d = 1'b0;
          if (needs_shift(a_d) || needs_shift(b_d)) begin
            state_d = NORM;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      NORM: begin
        a_d = norm_step(a_q);
        b_d = norm_step(b_q);
        // Exit on the same edge that applies the final shift.
        if (!needs_shift(a_d) && !needs_shift(b_d)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, handshake flags and working registers; all clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sign_a    = a_q.sign;
  assign bus.sign_b    = b_q.sign;
  assign bus.exp_a     = a_q.exp;
  assign bus.exp_b     = b_q.exp;
  assign bus.mant_a    = a_q.mant;
  assign bus.mant_b    = b_q.mant;
  assign bus.shift_a   = a_q.shift;
  assign bus.shift_b   = b_q.shift;
  assign bus.class_a   = a_q.cls;
  assign bus.class_b   = b_q.cls;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed bench for fp_operand_unpack: normal, subnormal, special and zero
// operands, output backpressure, and asynchronous reset during normalization.
module tb_fp_operand_unpack;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fp_operand_unpack_if bus ();

  fp_operand_unpack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold it until an edge where in_ready was high.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Count cycles after accept until out_valid; start is the current cycle offset.
  task automatic wait_out(input int start, input int want, input string tag);
    int lat;
    lat = start;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk(tag, 32'(lat), 32'(want));
  endtask

  task automatic chk_a(input string t, input logic s, input logic [9:0] e,
                       input logic [23:0] m, input logic [4:0] sh, input logic [4:0] c);
    chk({t, ".sign_a"},  32'(bus.sign_a),  32'(s));
    chk({t, ".exp_a"},   32'(bus.exp_a),   32'(e));
    chk({t, ".mant_a"},  32'(bus.mant_a),  32'(m));
    chk({t, ".shift_a"}, 32'(bus.shift_a), 32'(sh));
    chk({t, ".class_a"}, 32'(bus.class_a), 32'(c));
  endtask

  task automatic chk_b(input string t, input logic s, input logic [9:0] e,
                       input logic [23:0] m, input logic [4:0] sh, input logic [4:0] c);
    chk({t, ".sign_b"},  32'(bus.sign_b),  32'(s));
    chk({t, ".exp_b"},   32'(bus.exp_b),   32'(e));
    chk({t, ".mant_b"},  32'(bus.mant_b),  32'(m));
    chk({t, ".shift_b"}, 32'(bus.shift_b), 32'(sh));
    chk({t, ".class_b"}, 32'(bus.class_b), 32'(c));
  endtask

  // After a result is seen with out_ready high, the next cycle must be IDLE.
  task automatic chk_return(input string t);
    step();
    chk({t, ".in_ready_after"},  32'(bus.in_ready),  32'd1);
    chk({t, ".out_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk_a("rst", 1'b0, 10'h000, 24'h000000, 5'd0, 5'h00);
    chk_b("rst", 1'b0, 10'h000, 24'h000000, 5'd0, 5'h00);
    rst_n = 1'b1;
    step();
    chk("rel.in_ready",  32'(bus.in_ready),  32'd1);

    // Normal operands: 1.0 and -2.0
    send(32'h3F800000, 32'hC0000000);
    wait_out(1, 1, "norm.latency");
    chk("norm.in_ready_low", 32'(bus.in_ready), 32'd0);
    chk_a("norm", 1'b0, 10'h000, 24'h800000, 5'd0, 5'h00);
    chk_b("norm", 1'b1, 10'h001, 24'h800000, 5'd0, 5'h00);
    chk_return("norm");

    // Subnormals: smallest subnormal and 2^-127
    send(32'h00000001, 32'h00400000);
    chk("sub.c1.mant_a",    32'(bus.mant_a),    32'h000001);
    chk("sub.c1.out_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("sub.c2.mant_a",  32'(bus.mant_a),  32'h000002);
    chk("sub.c2.shift_a", 32'(bus.shift_a), 32'd1);
    chk_b("sub.c2", 1'b0, 10'h381, 24'h800000, 5'd1, 5'h01);
    repeat (10) step();
    chk_b("sub.c12", 1'b0, 10'h381, 24'h800000, 5'd1, 5'h01);
    chk("sub.c12.shift_a", 32'(bus.shift_a), 32'd11);
    wait_out(12, 24, "sub.latency");
    chk_a("sub", 1'b0, 10'h36B, 24'h800000, 5'd23, 5'h01);
    chk_b("sub", 1'b0, 10'h381, 24'h800000, 5'd1, 5'h01);
    chk_return("sub");

    // Specials: +Inf and signalling NaN
    send(32'h7F800000, 32'h7FA00000);
    wait_out(1, 1, "spec.latency");
    chk_a("spec", 1'b0, 10'h080, 24'h800000, 5'd0, 5'h04);
    chk_b("spec", 1'b0, 10'h080, 24'hA00000, 5'd0, 5'h18);
    chk_return("spec");

    // Quiet NaN on a, negative normal on b
    send(32'hFFC00001, 32'hBF000000);
    wait_out(1, 1, "qnan.latency");
    chk_a("qnan", 1'b1, 10'h080, 24'hC00001, 5'd0, 5'h08);
    chk_b("qnan", 1'b1, 10'h3FF, 24'h800000, 5'd0, 5'h00);
    chk_return("qnan");

    // Zero: -0 and +0
    send(32'h80000000, 32'h00000000);
    wait_out(1, 1, "zero.latency");
    chk_a("zero", 1'b1, 10'h000, 24'h000000, 5'd0, 5'h02);
    chk_b("zero", 1'b0, 10'h000, 24'h000000, 5'd0, 5'h02);
    chk_return("zero");

    // Backpressure: hold the result, present a second pair meanwhile
    bus.out_ready = 1'b0;
    send(32'h40400000, 32'hBF000000);
    wait_out(1, 1, "bp.latency");
    bus.op_a     = 32'h3F800000;
    bus.op_b     = 32'h7F800000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.hold.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.hold.in_ready",  32'(bus.in_ready),  32'd0);
      chk_a("bp.hold", 1'b0, 10'h001, 24'hC00000, 5'd0, 5'h00);
      chk_b("bp.hold", 1'b1, 10'h3FF, 24'h800000, 5'd0, 5'h00);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp.ret.in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp.ret.out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp.ret.mant_a",    32'(bus.mant_a),    32'hC00000);
    step();
    bus.in_valid = 1'b0;
    chk("bp.second.out_valid", 32'(bus.out_valid), 32'd1);
    chk_a("bp.second", 1'b0, 10'h000, 24'h800000, 5'd0, 5'h00);
    chk_b("bp.second", 1'b0, 10'h080, 24'h800000, 5'd0, 5'h04);
    chk_return("bp.second");

    // Reset mid-normalization
    send(32'h00000001, 32'h00400000);
    repeat (9) step();
    chk("rstn.pre.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstn.pre.shift_a",   32'(bus.shift_a),   32'd9);
    rst_n = 1'b0;
    #1;
    chk("rstn.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstn.in_ready",  32'(bus.in_ready),  32'd0);
    chk_a("rstn", 1'b0, 10'h000, 24'h000000, 5'd0, 5'h00);
    chk_b("rstn", 1'b0, 10'h000, 24'h000000, 5'd0, 5'h00);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rstn.rel.in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("rstn.no_out_valid", 32'(seen), 32'd0);

    // Fresh transaction after the aborted one
    send(32'h3F800000, 32'hC0000000);
    wait_out(1, 1, "post.latency");
    chk_a("post", 1'b0, 10'h000, 24'h800000, 5'd0, 5'h00);
    chk_b("post", 1'b1, 10'h001, 24'h800000, 5'd0, 5'h00);
    chk_return("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
